// File: rtl/wavetable_reader.sv
// Phase-accumulator wavetable oscillator: each tick fetches two adjacent samples from a
// registered-read RAM and linearly interpolates between them.
module wavetable_reader #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int TABLE_BITS  = 8,
  parameter int PHASE_WIDTH = 24,
  parameter int FRAC_BITS   = 8,
  parameter int INTERP_EN   = 1
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic                             i_sample_tick,
  input  logic [PHASE_WIDTH-1:0]           i_tuning_word,
  input  logic [ADDR_WIDTH-TABLE_BITS-1:0] i_table_select,
  input  logic                             i_ram_hold,
  input  logic [DATA_WIDTH-1:0]            i_ram_data,
  output logic [ADDR_WIDTH-1:0]            o_ram_address,
  output logic                             o_ram_active,
  output logic [DATA_WIDTH-1:0]            o_sample,
  output logic                             o_sample_valid,
  output logic                             o_overrun
);
  localparam int SEL_W  = ADDR_WIDTH - TABLE_BITS;
  localparam int WORK_W = TABLE_BITS + FRAC_BITS;
  localparam int PROD_W = DATA_WIDTH + FRAC_BITS + 2;

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, CAP_B, INTERP} state_t;

  state_t                         state, state_nxt;
  logic [PHASE_WIDTH-1:0]         phase;
  logic [WORK_W-1:0]              work_phase;
  logic                           pending;
  logic                           busy;
  logic                           start;
  logic [SEL_W-1:0]               table_r;
  logic signed [DATA_WIDTH-1:0]   sample_a, sample_b;
  logic [TABLE_BITS-1:0]          idx, idx_b;
  logic [FRAC_BITS-1:0]           frac;

  // Floor-rounded linear interpolation; the result stays between a and b.
  function automatic logic signed [DATA_WIDTH-1:0] lerp(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b,
    input logic [FRAC_BITS-1:0]         f
  );
    logic signed [DATA_WIDTH:0] d;
    logic signed [PROD_W-1:0]   p;
    logic signed [PROD_W-1:0]   s;
    d = {b[DATA_WIDTH-1], b} - {a[DATA_WIDTH-1], a};
    p = PROD_W'(d) * PROD_W'($signed({1'b0, f}));
    s = (p >>> FRAC_BITS) + PROD_W'(a);
    return s[DATA_WIDTH-1:0];
  endfunction

  assign idx   = work_phase[WORK_W-1 -: TABLE_BITS];
  assign frac  = work_phase[FRAC_BITS-1:0];
  assign idx_b = idx + TABLE_BITS'(1);
  assign busy  = (state != IDLE);
  assign start = (state == IDLE) && (pending || i_sample_tick) && !i_ram_hold;

  always_comb begin
    state_nxt     = state;
    o_ram_active  = 1'b0;
    o_ram_address = '0;
    case (state)
      IDLE:   if (start) state_nxt = RD_A;
      RD_A: begin
        state_nxt     = RD_B;
        o_ram_active  = 1'b1;
        o_ram_address = {i_table_select, idx};
      end
      RD_B: begin
        state_nxt     = CAP_B;
        o_ram_active  = 1'b1;
        o_ram_address = {table_r, idx_b};
      end
      CAP_B: begin
        state_nxt     = INTERP;
        o_ram_active  = 1'b1;
        o_ram_address = {table_r, idx_b};
      end
      INTERP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state          <= IDLE;
      phase          <= '0;
      pending        <= 1'b0;
      o_overrun      <= 1'b0;
      o_sample_valid <= 1'b0;
      o_sample       <= '0;
    end else begin
      state          <= state_nxt;
      o_overrun      <= i_sample_tick && (pending || busy);
      o_sample_valid <= (state == INTERP);
      if (i_sample_tick) phase <= phase + i_tuning_word;
      if (start)
        pending <= 1'b0;
      else if (i_sample_tick && !busy)
        pending <= 1'b1;
      if (state == INTERP)
        o_sample <= (INTERP_EN != 0) ? lerp(sample_a, sample_b, frac) : sample_a;
    end
  end

  // Fetch datapath: ticks while busy are dropped, so work_phase is stable during a fetch
  always_ff @(posedge i_clock) begin
    if (i_sample_tick && !busy) work_phase <= phase[PHASE_WIDTH-1 -: WORK_W];
    if (state == RD_A)  table_r  <= i_table_select;
    if (state == RD_B)  sample_a <= i_ram_data;
    if (state == CAP_B) sample_b <= i_ram_data;
  end
endmodule

// File: tb/tb_wavetable_reader.sv
// Bench for wavetable_reader: RAM model, phase model and interpolation reference in plain arithmetic.
module tb_wavetable_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic [23:0] tuning = '0;
  logic [7:0]  tsel = '0;
  logic        hold = 1'b0;
  logic [7:0]  ram_data, ram_data0;
  logic [15:0] addr, addr0;
  logic        active, active0;
  logic [7:0]  sample, sample0;
  logic        valid, valid0;
  logic        overrun, overrun0;

  logic [7:0]  mem [0:65535];
  logic [23:0] mphase;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    ram_data  <= mem[addr];
    ram_data0 <= mem[addr0];
  end

  wavetable_reader #(.INTERP_EN(1)) dut (
    .i_clock(clk), .i_reset(rst), .i_sample_tick(tick), .i_tuning_word(tuning),
    .i_table_select(tsel), .i_ram_hold(hold), .i_ram_data(ram_data),
    .o_ram_address(addr), .o_ram_active(active), .o_sample(sample),
    .o_sample_valid(valid), .o_overrun(overrun));

  wavetable_reader #(.INTERP_EN(0)) dut0 (
    .i_clock(clk), .i_reset(rst), .i_sample_tick(tick), .i_tuning_word(tuning),
    .i_table_select(tsel), .i_ram_hold(hold), .i_ram_data(ram_data0),
    .o_ram_address(addr0), .o_ram_active(active0), .o_sample(sample0),
    .o_sample_valid(valid0), .o_overrun(overrun0));

  function automatic int ref_interp(input logic [23:0] ph, input logic [7:0] sel);
    logic [7:0] ia, ib;
    int a, b, f, num, q;
    ia  = ph[23:16];
    ib  = ia + 8'd1;
    a   = int'($signed(mem[{sel, ia}]));
    b   = int'($signed(mem[{sel, ib}]));
    f   = int'(ph[15:8]);
    num = (b - a) * f;
    q   = num / 256;
    if (num < 0 && (num % 256) != 0) q = q - 1;
    return a + q;
  endfunction

  function automatic int ref_plain(input logic [23:0] ph, input logic [7:0] sel);
    return int'($signed(mem[{sel, ph[23:16]}]));
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick = 1'b0; hold = 1'b0;
    step(2);
    rst = 1'b0;
    mphase = '0;
  endtask

  task automatic fire(input logic [23:0] tw, input logic [7:0] sel,
                      output logic [23:0] ph, output int t);
    tuning = tw; tsel = sel; tick = 1'b1;
    ph = mphase; t = cyc;
    mphase = mphase + tw;
    step(1);
    tick = 1'b0;
  endtask

  task automatic wait_valid(output int vc, output bit got);
    got = 1'b0; vc = -1;
    for (int i = 0; i < 40; i++) begin
      if (valid) begin got = 1'b1; vc = cyc; break; end
      step(1);
    end
  endtask

  task automatic test_reset();
    logic [23:0] ph; int t, vc, e; bit got, seen;
    do_reset();
    n_cmp++;
    if ({sample, valid, overrun, active, addr} !== '0) begin
      n_bad++; $display("FAIL reset_outputs got=%h required=0", {sample, valid, overrun, active, addr});
    end
    fire(24'h123456, 8'd3, ph, t);
    step(1);
    rst = 1'b1; step(2); rst = 1'b0; mphase = '0;
    n_cmp++;
    if ({sample, valid, overrun, active, addr} !== '0) begin
      n_bad++; $display("FAIL reset_midfetch got=%h required=0", {sample, valid, overrun, active, addr});
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (valid || active) seen = 1'b1;
      step(1);
    end
    n_cmp++;
    if (seen) begin n_bad++; $display("FAIL reset_abort activity after reset seen=1 required=0"); end
    fire(24'h0A0000, 8'd3, ph, t);
    wait_valid(vc, got);
    e = ref_interp(24'h000000, 8'd3);
    n_cmp++;
    if (!got || sample !== e[7:0]) begin
      n_bad++; $display("FAIL reset_phase0 got=%h required=%h valid=%0d", sample, e[7:0], got);
    end
  endtask

  task automatic test_ramp();
    logic [23:0] ph; int t, vc; bit got; logic [7:0] k8;
    do_reset();
    for (int k = 0; k < 128; k++) mem[k] = 8'(k);
    for (int i = 0; i < 4; i++) begin
      k8 = 8'(i);
      fire(24'h010000, 8'd0, ph, t);
      wait_valid(vc, got);
      n_cmp++;
      if (!got || vc != t + 5) begin
        n_bad++; $display("FAIL ramp_latency got=%0d required=%0d", vc - t, 5);
      end
      n_cmp++;
      if (sample !== k8 || sample0 !== k8) begin
        n_bad++; $display("FAIL ramp_sample got=%h/%h required=%h", sample, sample0, k8);
      end
      step(15);
    end
  endtask

  task automatic test_interp();
    logic [23:0] ph; int t, vc; bit got;
    do_reset();
    mem[16'h0510] = 8'd10; mem[16'h0511] = 8'd20;
    fire(24'h108000, 8'd5, ph, t); wait_valid(vc, got); step(2);
    fire(24'h108000, 8'd5, ph, t); wait_valid(vc, got);
    n_cmp++;
    if (!got || sample !== 8'd15 || sample0 !== 8'd10) begin
      n_bad++; $display("FAIL interp_pos got=%h/%h required=0f/0a", sample, sample0);
    end
    step(2);
    mem[16'h0510] = 8'hF6; mem[16'h0511] = 8'hEC;
    fire(24'h104000 - mphase, 8'd5, ph, t); wait_valid(vc, got); step(2);
    fire(24'h000100, 8'd5, ph, t); wait_valid(vc, got);
    n_cmp++;
    if (!got || sample !== 8'hF3 || sample0 !== 8'hF6) begin
      n_bad++; $display("FAIL interp_neg got=%h/%h required=f3/f6", sample, sample0);
    end
  endtask

  task automatic test_wrap();
    logic [23:0] ph; int t, vc, e; bit got;
    do_reset();
    mem[16'h02FF] = 8'h40; mem[16'h0200] = 8'hC0; mem[16'h0300] = 8'h11;
    fire(24'hFF0000, 8'd2, ph, t); wait_valid(vc, got); step(2);
    fire(24'h00FFFF, 8'd2, ph, t);
    n_cmp++;
    if (!active || addr !== 16'h02FF) begin
      n_bad++; $display("FAIL wrap_addr_a got=%h required=02ff", addr);
    end
    step(1);
    n_cmp++;
    if (!active || addr !== 16'h0200) begin
      n_bad++; $display("FAIL wrap_addr_b got=%h required=0200", addr);
    end
    wait_valid(vc, got); step(2);
    fire(24'h000002, 8'd2, ph, t); wait_valid(vc, got);
    e = ref_interp(24'hFFFFFF, 8'd2);
    n_cmp++;
    if (!got || sample !== e[7:0]) begin
      n_bad++; $display("FAIL wrap_frac got=%h required=%h", sample, e[7:0]);
    end
    step(2);
    fire(24'h000010, 8'd2, ph, t); wait_valid(vc, got);
    n_cmp++;
    if (!got || sample !== 8'hC0) begin
      n_bad++; $display("FAIL wrap_phase got=%h required=c0", sample);
    end
  endtask

  task automatic test_hold();
    logic [23:0] ph; int t, r, vc, e; bit got, bad;
    do_reset();
    hold = 1'b1;
    fire(24'h035A00, 8'd7, ph, t);
    fire(24'h021000, 8'd7, ph, t);
    r = t + 10; bad = 1'b0;
    while (cyc < r) begin
      if (active) bad = 1'b1;
      step(1);
    end
    hold = 1'b0;
    if (active) bad = 1'b1;
    step(1);
    n_cmp++;
    if (bad || !active) begin
      n_bad++; $display("FAIL hold_active early=%0d active_at_r1=%0d required early=0 active=1", bad, active);
    end
    wait_valid(vc, got);
    n_cmp++;
    if (!got || vc != r + 5) begin
      n_bad++; $display("FAIL hold_latency got=%0d required=%0d", vc, r + 5);
    end
    e = ref_interp(ph, 8'd7);
    n_cmp++;
    if (sample !== e[7:0]) begin
      n_bad++; $display("FAIL hold_reload got=%h required=%h", sample, e[7:0]);
    end
  endtask

  task automatic test_overrun();
    logic [23:0] ph1, ph2, ph3; int t1, t2, t3, vc, e; bit got;
    do_reset();
    fire(24'h123456, 8'd9, ph1, t1);
    step(1);
    fire(24'h123456, 8'd9, ph2, t2);
    n_cmp++;
    if (overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_pulse got=%b required=1", overrun); end
    step(1);
    n_cmp++;
    if (overrun !== 1'b0) begin n_bad++; $display("FAIL overrun_width got=%b required=0", overrun); end
    wait_valid(vc, got);
    e = ref_interp(ph1, 8'd9);
    n_cmp++;
    if (!got || vc != t1 + 5 || sample !== e[7:0]) begin
      n_bad++; $display("FAIL overrun_sample got=%h required=%h", sample, e[7:0]);
    end
    step(2);
    fire(24'h000100, 8'd9, ph3, t3); wait_valid(vc, got);
    e = ref_interp(ph3, 8'd9);
    n_cmp++;
    if (!got || sample !== e[7:0]) begin
      n_bad++; $display("FAIL overrun_phase got=%h required=%h", sample, e[7:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] ph; int t, vc, e; bit got;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      fire(24'($urandom), 8'($urandom), ph, t);
      n_cmp++;
      if (overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_overrun got=%b required=0", overrun); end
      wait_valid(vc, got);
      e = ref_interp(ph, tsel);
      n_cmp++;
      if (!got || vc != t + 5 || sample !== e[7:0]) begin
        n_bad++; $display("FAIL b2b_sample got=%h required=%h lat=%0d", sample, e[7:0], vc - t);
      end
    end
  endtask

  task automatic test_random();
    logic [23:0] ph; int t, vc, e, p; bit got;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      fire(24'($urandom), 8'($urandom_range(0, 15)), ph, t);
      wait_valid(vc, got);
      e = ref_interp(ph, tsel);
      p = ref_plain(ph, tsel);
      n_cmp++;
      if (!got || vc != t + 5 || sample !== e[7:0] || sample0 !== p[7:0]) begin
        n_bad++;
        $display("FAIL random_sample got=%h/%h required=%h/%h phase=%h lat=%0d",
                 sample, sample0, e[7:0], p[7:0], ph, vc - t);
      end
      step($urandom_range(0, 4));
    end
  endtask

  initial begin
    for (int k = 0; k < 65536; k++) mem[k] = 8'($urandom);
    mphase = '0;
    test_reset();
    test_ramp();
    test_interp();
    test_wrap();
    test_hold();
    test_overrun();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
